// File: rtl/apuf_challenge_driver.sv
// Challenge/trigger sequencer for a 64-stage arbiter PUF; emits challenge/response pairs on valid/ready.
// Optional build macro APUF_MAJORITY_VOTE_EN: each challenge is evaluated NVOTE times and the majority is reported.
module apuf_challenge_driver #(
  parameter int CW          = 64,
  parameter int SETTLE_CYC  = 4,
  parameter int RELAX_CYC   = 4,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 16
`ifdef APUF_MAJORITY_VOTE_EN
  ,
  parameter int NVOTE       = 5
`endif
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             start,
  input  logic [CNT_W-1:0] numCrp,
  input  logic             seedLoad,
  input  logic [CW-1:0]    seed,
  output logic [CW-1:0]    c,
  output logic             tigSignal,
  input  logic             respReady,
  input  logic             respBit,
  output logic             crpValid,
  input  logic             crpReady,
  output logic [CW-1:0]    crpChal,
  output logic             crpResp,
  output logic             crpTimeout,
  output logic             busy,
  output logic             done
);
  localparam int TW = 16;
  // Galois taps for x^64+x^63+x^61+x^60+1, right-shifting form
  localparam logic [CW-1:0] TAPS = CW'(64'hD800_0000_0000_0000);

  typedef enum logic [2:0] {IDLE, SETTLE, WAIT, OUT, RELAX} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    lfsr, lfsr_next, lfsr_adv, c_next, chal_next;
  logic [CNT_W-1:0] remaining, remaining_next;
  logic [TW-1:0]    cnt, cnt_next;
  logic             last_crp, last_next;
  logic             tig_next, valid_next, resp_next, timeout_next, busy_next;
  logic             resolve;
`ifdef APUF_MAJORITY_VOTE_EN
  logic [7:0]       vote_idx, vote_idx_next, ones, ones_next, touts, touts_next;
  logic [7:0]       ones_sum, touts_sum;

  assign ones_sum  = ones + 8'(respReady & respBit);
  assign touts_sum = touts + 8'(!respReady);
`endif

  assign lfsr_adv = {1'b0, lfsr[CW-1:1]} ^ (lfsr[0] ? TAPS : '0);
  assign resolve  = respReady || (cnt == TW'(TIMEOUT_CYC - 1));
  assign done     = (state == OUT) && crpReady && (remaining == CNT_W'(1));

  always_comb begin
    state_next     = state;
    lfsr_next      = lfsr;
    remaining_next = remaining;
    cnt_next       = cnt;
    last_next      = last_crp;
    c_next         = c;
    tig_next       = tigSignal;
    valid_next     = crpValid;
    chal_next      = crpChal;
    resp_next      = crpResp;
    timeout_next   = crpTimeout;
    busy_next      = busy;
`ifdef APUF_MAJORITY_VOTE_EN
    vote_idx_next  = vote_idx;
    ones_next      = ones;
    touts_next     = touts;
`endif
    case (state)
      IDLE: begin
        if (seedLoad) begin
          lfsr_next = (seed == '0) ? CW'(1) : seed;
        end else if (start) begin
          remaining_next = (numCrp == '0) ? CNT_W'(1) : numCrp;
          c_next         = lfsr;
          busy_next      = 1'b1;
          cnt_next       = '0;
          state_next     = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt == TW'(SETTLE_CYC - 1)) begin
          cnt_next   = '0;
          tig_next   = 1'b1;
          state_next = WAIT;
        end else begin
          cnt_next = cnt + TW'(1);
        end
      end
      WAIT: begin
        if (resolve) begin
          tig_next = 1'b0;
          cnt_next = '0;
`ifdef APUF_MAJORITY_VOTE_EN
          if (vote_idx == 8'(NVOTE - 1)) begin
            valid_next    = 1'b1;
            chal_next     = c;
            resp_next     = (ones_sum > 8'(NVOTE / 2));
            timeout_next  = (touts_sum == 8'(NVOTE));
            vote_idx_next = '0;
            ones_next     = '0;
            touts_next    = '0;
            state_next    = OUT;
          end else begin
            vote_idx_next = vote_idx + 8'd1;
            ones_next     = ones_sum;
            touts_next    = touts_sum;
            state_next    = RELAX;
          end
`else
          valid_next   = 1'b1;
          chal_next    = c;
          resp_next    = respReady & respBit;
          timeout_next = !respReady;
          state_next   = OUT;
`endif
        end else begin
          cnt_next = cnt + TW'(1);
        end
      end
      OUT: begin
        if (crpReady) begin
          valid_next     = 1'b0;
          lfsr_next      = lfsr_adv;
          remaining_next = remaining - CNT_W'(1);
          last_next      = (remaining == CNT_W'(1));
          cnt_next       = '0;
          state_next     = RELAX;
        end
      end
      RELAX: begin
        if (cnt != TW'(RELAX_CYC - 1)) begin
          cnt_next = cnt + TW'(1);
        end else if (!respReady) begin
          cnt_next = '0;
          if (last_crp) begin
            busy_next  = 1'b0;
            last_next  = 1'b0;
            state_next = IDLE;
          end else begin
`ifdef APUF_MAJORITY_VOTE_EN
            // mid-vote repeats keep the same challenge
            if (vote_idx == 8'd0) c_next = lfsr;
`else
            c_next = lfsr;
`endif
            state_next = SETTLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state      <= IDLE;
      lfsr       <= CW'(1);
      remaining  <= '0;
      cnt        <= '0;
      last_crp   <= 1'b0;
      c          <= '0;
      tigSignal  <= 1'b0;
      crpValid   <= 1'b0;
      crpChal    <= '0;
      crpResp    <= 1'b0;
      crpTimeout <= 1'b0;
      busy       <= 1'b0;
`ifdef APUF_MAJORITY_VOTE_EN
      vote_idx   <= '0;
      ones       <= '0;
      touts      <= '0;
`endif
    end else begin
      state      <= state_next;
      lfsr       <= lfsr_next;
      remaining  <= remaining_next;
      cnt        <= cnt_next;
      last_crp   <= last_next;
      c          <= c_next;
      tigSignal  <= tig_next;
      crpValid   <= valid_next;
      crpChal    <= chal_next;
      crpResp    <= resp_next;
      crpTimeout <= timeout_next;
      busy       <= busy_next;
`ifdef APUF_MAJORITY_VOTE_EN
      vote_idx   <= vote_idx_next;
      ones       <= ones_next;
      touts      <= touts_next;
`endif
    end
  end

endmodule

// File: doc/apuf_challenge_driver.md
Name: apuf_challenge_driver

Overview:
- Upstream sequencer for the classic 64-stage arbiter PUF.
- Generates 64-bit challenges from an LFSR and drives them with the trigger on the PUF's challenge and trigger inputs.
- Waits for the PUF's response-ready flag, captures the response bit, and presents each challenge/response pair (CRP) downstream on a valid/ready handshake.
- Produces a programmed number of CRPs per start command.

Parameters:
- CW, 64, challenge width; must equal the PUF stage count.
- SETTLE_CYC, 4, cycles the challenge is held stable before the trigger rises (1..255).
- RELAX_CYC, 4, minimum cycles the trigger stays low between evaluations (1..255).
- TIMEOUT_CYC, 1024, maximum cycles to wait for respReady after the trigger rises (2..65535).
- CNT_W, 16, width of the CRP count.

Ports:
- clk  in  1  system clock; all logic rises on posedge.
- rstN  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- numCrp  in  CNT_W  number of CRPs to produce; 0 is treated as 1.
- seedLoad  in  1  in IDLE, loads lfsr with seed.
- seed  in  CW  LFSR seed; all-zero is replaced by 1.
- c  out  CW  challenge to the PUF.
- tigSignal  out  1  PUF trigger.
- respReady  in  1  PUF resolved flag, synchronous to clk.
- respBit  in  1  PUF response, valid while respReady=1.
- crpValid  out  1  CRP available.
- crpReady  in  1  downstream accepts CRP.
- crpChal  out  CW  challenge of the presented CRP.
- crpResp  out  1  response of the presented CRP.
- crpTimeout  out  1  presented CRP timed out; crpResp is forced to 0.
- busy  out  1  high from start accept until return to IDLE.
- done  out  1  one-cycle pulse on the final CRP handshake.

Behaviour:
- Reset values: lfsr=1; c=0; tigSignal=0; crpValid=0; crpChal=0; crpResp=0; crpTimeout=0; busy=0; done=0; state=IDLE; all counters=0.
- Reset mid-operation: all of the above take effect immediately, including tigSignal dropping asynchronously.
- LFSR: 64-bit Galois, polynomial x^64+x^63+x^61+x^60+1. Advances exactly once per accepted CRP.
- States:
  - IDLE: seedLoad takes priority over start. start sets remaining=max(numCrp,1), drives c=lfsr, sets busy=1, and moves to SETTLE.
  - SETTLE: counts SETTLE_CYC cycles with tigSignal=0, then sets tigSignal=1 and moves to WAIT.
  - WAIT: on the first cycle with respReady=1, latches crpResp=respBit, crpChal=c, crpTimeout=0. If TIMEOUT_CYC cycles elapse first, latches crpResp=0, crpTimeout=1. Either way, sets tigSignal=0, crpValid=1, and moves to OUT.
  - OUT: holds crpValid and all crp* outputs stable until crpReady=1. On the handshake cycle: crpValid drops next cycle, lfsr advances, remaining decrements. If remaining was 1, pulses done and moves to RELAX with a final flag set; otherwise moves to RELAX.
  - RELAX: holds tigSignal=0 for at least RELAX_CYC cycles and until respReady=0. Then either returns to IDLE (final, busy=0) or drives c=lfsr and moves to SETTLE.
- tigSignal low-to-high edges occur only from SETTLE. The challenge c never changes while tigSignal=1 or during SETTLE.
- respReady is ignored outside WAIT.
- start is ignored while busy=1.
- crpReady held high continuously gives one CRP per SETTLE_CYC + RELAX_CYC + response latency + 2 cycles.

Optional Feature:
- Macro: APUF_MAJORITY_VOTE_EN.
- When defined: each challenge is evaluated NVOTE times. NVOTE is an odd parameter, default 5.
  - Repeat loop: WAIT → RELAX → SETTLE, with the same c.
  - crpResp = majority of the captured bits.
  - Timed-out evaluations count as 0.
  - crpTimeout=1 only if all NVOTE evaluations timed out.
  - The LFSR advances only after the CRP handshake.
- When not defined: single evaluation per challenge as described above.

Test Plan:
- Seed 64'h1, numCrp=3, PUF model answers respReady after 6 cycles with respBit=c[0]^c[63], crpReady tied 1 → three CRPs with crpChal=1, then successive Galois LFSR values; done pulses once; busy clears.
- seed=0 loaded → lfsr=1; first crpChal=64'h1.
- respReady never asserted, TIMEOUT_CYC=16 → crpTimeout=1, crpResp=0, tigSignal drops after 16 cycles, next CRP proceeds.
- crpReady held 0 for 50 cycles in OUT → crpValid, crpChal and crpResp stable; tigSignal=0; LFSR unchanged.
- Assert rstN low while in WAIT with tigSignal=1 → tigSignal=0 immediately; all outputs at reset values; later start works normally.
- With APUF_MAJORITY_VOTE_EN and NVOTE=5, response sequence 1,0,1,1,0 → crpResp=1; exactly 5 trigger pulses on an unchanged c.
